// File: rtl/fp_arith_pipe.sv
// fp_arith_pipe
//   Four-stage valid/ready pipeline: signed int pair -> float convert ->
//   float multiply and add -> normalise (round toward zero) -> saturating
//   float-to-int. Float format is {sign, exp[EXP-1:0], man[MAN-1:0]} with a
//   hidden leading one; zero is all-zeros.
//   Optional feature macro: FP_PIPE_FLAGS_EN (adds the ovf_m output).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in1, in2         MAN-bit signed operands
//   in_valid/ready   input handshake (in_ready = global pipeline enable)
//   out_m, out_s     saturated product, exact sum (MAN+EXP+1 bits, signed)
//   out_valid/ready  output handshake
//   ovf_m            product saturated (FP_PIPE_FLAGS_EN only)
module fp_arith_pipe #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAN-1:0]   in1,
  input  logic [MAN-1:0]   in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [MAN+EXP:0] out_m,
  output logic [MAN+EXP:0] out_s,
  output logic             out_valid,
`ifdef FP_PIPE_FLAGS_EN
  output logic             ovf_m,
`endif
  input  logic             out_ready
);

  localparam int FW   = 1 + EXP + MAN;
  localparam int OW   = MAN + EXP + 1;
  localparam int PW   = 2 * (MAN + 1);
  localparam int SW   = 2 * MAN + 2;
  localparam int BIAS = 2 ** (EXP - 1) - 1;
  localparam logic [OW-1:0] MINMAG = {1'b1, {(OW-1){1'b0}}};

  // Exact integer -> float; -2^(MAN-1) negates to 2^(MAN-1), which still fits unsigned.
  function automatic logic [FW-1:0] int2fp(input logic [MAN-1:0] x);
    logic [MAN-1:0] mag;
    int unsigned    p;
    mag = x[MAN-1] ? (~x + 1'b1) : x;
    p = 0;
    for (int unsigned i = 0; i < MAN; i++)
      if (mag[i]) p = i;
    if (mag == '0) return '0;
    return {x[MAN-1], EXP'(BIAS + int'(p)), MAN'(mag << (MAN - p))};
  endfunction

  function automatic int unsigned msb_pos(input logic [SW-1:0] v);
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < SW; i++)
      if (v[i]) p = i;
    return p;
  endfunction

  // {too_big, truncated magnitude}; too_big means |f| >= 2^OW.
  function automatic logic [OW:0] fp_mag(input logic [FW-1:0] f);
    int                 e;
    logic [MAN+OW-1:0]  wide;
    e    = int'(f[FW-2:MAN]) - BIAS;
    wide = '0;
    if (f[FW-2:MAN] != '0 && e >= 0 && e < OW)
      wide = (MAN+OW)'({1'b1, f[MAN-1:0]}) << e;
    return {(f[FW-2:MAN] != '0) && (e >= OW), OW'(wide >> MAN)};
  endfunction

  // -2^(OW-1) is representable, so a negative magnitude of exactly MINMAG is not an overflow.
  function automatic logic fp_ovf(input logic [FW-1:0] f);
    logic [OW:0] m;
    m = fp_mag(f);
    return m[OW] | (f[FW-1] ? (m[OW-1:0] > MINMAG) : m[OW-1]);
  endfunction

  function automatic logic [OW-1:0] fp2int(input logic [FW-1:0] f);
    logic [OW:0] m;
    m = fp_mag(f);
    if (fp_ovf(f)) return f[FW-1] ? MINMAG : ~MINMAG;
    return f[FW-1] ? -m[OW-1:0] : m[OW-1:0];
  endfunction

  logic w_en;
  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;

  // Stage 1 registers: converted operands
  logic            r_v1;
  logic [FW-1:0]   r_a, r_b;
  // Stage 2 registers: raw product and aligned sum
  logic            r_v2, r_p_zero, r_p_sign;
  logic [EXP-1:0]  r_p_exp, r_s_emin;
  logic [MAN+1:0]  r_p_hi;
  logic [SW-1:0]   r_s_sum;
  // Stage 3 registers: normalised float results
  logic            r_v3;
  logic [FW-1:0]   r_fm, r_fs;

  // Stage 2 combinational arithmetic
  logic            w_a_zero, w_b_zero;
  logic [EXP-1:0]  w_ea, w_eb, w_emin, w_p_exp;
  logic [PW-1:0]   w_p_prod;
  logic [SW-1:0]   w_a_al, w_b_al, w_sum;

  always_comb begin
    w_ea     = r_a[FW-2:MAN];
    w_eb     = r_b[FW-2:MAN];
    w_a_zero = (w_ea == '0);
    w_b_zero = (w_eb == '0);
    w_p_prod = PW'({1'b1, r_a[MAN-1:0]}) * PW'({1'b1, r_b[MAN-1:0]});
    w_p_exp  = EXP'(int'(w_ea) + int'(w_eb) - BIAS);
    // Align to the smaller exponent by shifting the larger operand left: no bits lost.
    if (w_a_zero)      w_emin = w_eb;
    else if (w_b_zero) w_emin = w_ea;
    else               w_emin = (w_ea < w_eb) ? w_ea : w_eb;
    w_a_al = w_a_zero ? '0 : SW'({1'b1, r_a[MAN-1:0]}) << (w_ea - w_emin);
    w_b_al = w_b_zero ? '0 : SW'({1'b1, r_b[MAN-1:0]}) << (w_eb - w_emin);
    w_sum  = (r_a[FW-1] ? -w_a_al : w_a_al) + (r_b[FW-1] ? -w_b_al : w_b_al);
  end

  // Stage 3 combinational normalisation
  logic            w_s_neg;
  logic [SW-1:0]   w_s_mag;
  int unsigned     w_s_q;
  logic [FW-1:0]   w_fm, w_fs;

  always_comb begin
    if (r_p_zero)
      w_fm = '0;
    else if (r_p_hi[MAN+1])
      w_fm = {r_p_sign, r_p_exp + EXP'(1), r_p_hi[MAN:1]};
    else
      w_fm = {r_p_sign, r_p_exp, r_p_hi[MAN-1:0]};
    w_s_neg = r_s_sum[SW-1];
    w_s_mag = w_s_neg ? -r_s_sum : r_s_sum;
    w_s_q   = msb_pos(w_s_mag);
    if (r_s_sum == '0)
      w_fs = '0;
    else
      w_fs = {w_s_neg, EXP'(int'(r_s_emin) + int'(w_s_q) - MAN),
              MAN'((w_s_mag << (SW - 1 - w_s_q)) >> (SW - 1 - MAN))};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_v2      <= 1'b0;
      r_p_zero  <= 1'b1;
      r_p_sign  <= 1'b0;
      r_p_exp   <= '0;
      r_p_hi    <= '0;
      r_s_emin  <= '0;
      r_s_sum   <= '0;
      r_v3      <= 1'b0;
      r_fm      <= '0;
      r_fs      <= '0;
      out_valid <= 1'b0;
      out_m     <= '0;
      out_s     <= '0;
`ifdef FP_PIPE_FLAGS_EN
      ovf_m     <= 1'b0;
`endif
    end else if (w_en) begin
      r_v1      <= in_valid;
      r_a       <= int2fp(in1);
      r_b       <= int2fp(in2);
      r_v2      <= r_v1;
      r_p_zero  <= w_a_zero | w_b_zero;
      r_p_sign  <= r_a[FW-1] ^ r_b[FW-1];
      r_p_exp   <= w_p_exp;
      r_p_hi    <= (MAN+2)'(w_p_prod >> MAN);
      r_s_emin  <= w_emin;
      r_s_sum   <= w_sum;
      r_v3      <= r_v2;
      r_fm      <= w_fm;
      r_fs      <= w_fs;
      out_valid <= r_v3;
      out_m     <= fp2int(r_fm);
      out_s     <= fp2int(r_fs);
`ifdef FP_PIPE_FLAGS_EN
      ovf_m     <= fp_ovf(r_fm);
`endif
    end
  end

endmodule
